// File: rtl/fp_shift_pkg.sv
// fp_shift_pkg: shared widths, FSM state and G/R/S bundle for the FP shifters (rev 1.0)
`default_nettype none

package fp_shift_pkg;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int SELECT_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } grs_t;

  // Stage counter needs at least one bit even for a single-stage shifter
  function automatic int stage_width(input int sel_w);
    return (sel_w > 1) ? $clog2(sel_w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_right_stage.sv
// shift_right_stage: one log2 right-shift stage on the {data,g,r} word, reporting the OR of dropped bits (rev 1.0)
`default_nettype none

module shift_right_stage
  import fp_shift_pkg::*;
#(
  parameter  int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter  int SELECT_WIDTH = SELECT_WIDTH_DEF,
  localparam int STAGE_W      = stage_width(SELECT_WIDTH),
  localparam int EXT_W        = DATA_WIDTH + 2
) (
  input  logic [EXT_W-1:0]   ext_in,
  input  logic [STAGE_W-1:0] stage,
  input  logic               en,
  output logic [EXT_W-1:0]   ext_out,
  output logic               dropped
);

  logic [SELECT_WIDTH-1:0] amt;
  logic [EXT_W-1:0]        mask;

  always_comb begin
    amt     = SELECT_WIDTH'(1) << stage;
    // Low 2^stage bits of the word are the ones that fall off below bit 0
    mask    = ~({EXT_W{1'b1}} << amt);
    ext_out = ext_in;
    dropped = 1'b0;
    if (en) begin
      ext_out = ext_in >> amt;
      dropped = |(ext_in & mask);
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle logical right shifter, one log2 stage per clock, with G/R/S outputs (rev 1.0)
`default_nettype none

module shift_right_seq
  import fp_shift_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int SELECT_WIDTH = SELECT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in,
  input  logic [SELECT_WIDTH-1:0] shift_num,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out,
  output logic                    guard,
  output logic                    round,
  output logic                    sticky
);

  localparam int STAGE_W = stage_width(SELECT_WIDTH);
  localparam int EXT_W   = DATA_WIDTH + 2;

  state_t                  state;
  logic [EXT_W-1:0]        ext;
  logic                    sticky_acc;
  logic [SELECT_WIDTH-1:0] shamt;
  logic [STAGE_W-1:0]      stage;
  grs_t                    grs_q;

  logic [EXT_W-1:0]        ext_next;
  logic                    dropped;
  logic                    stage_en;

  assign stage_en = shamt[stage];

  shift_right_stage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SELECT_WIDTH(SELECT_WIDTH)
  ) u_stage (
    .ext_in (ext),
    .stage  (stage),
    .en     (stage_en),
    .ext_out(ext_next),
    .dropped(dropped)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ext        <= '0;
      sticky_acc <= 1'b0;
      shamt      <= '0;
      stage      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out        <= '0;
      grs_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            ext        <= {in, 2'b00};
            sticky_acc <= 1'b0;
            shamt      <= shift_num;
            stage      <= STAGE_W'(SELECT_WIDTH - 1);
            in_ready   <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          ext        <= ext_next;
          sticky_acc <= sticky_acc | dropped;
          if (stage == '0) begin
            // Publish straight from the last stage so results appear with the DONE state
            out          <= ext_next[EXT_W-1:2];
            grs_q.guard  <= ext_next[1];
            grs_q.round  <= ext_next[0];
            grs_q.sticky <= sticky_acc | dropped;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            stage <= stage - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out       <= '0;
            grs_q     <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign guard  = grs_q.guard;
  assign round  = grs_q.round;
  assign sticky = grs_q.sticky;

endmodule

`default_nettype wire

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: directed and random checks of shift_right_seq against an arithmetic reference
`default_nettype none

module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic [4:0]  shift_num;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        grd, rnd, stk;

  int checks = 0;
  int errors = 0;

  shift_right_seq #(.DATA_WIDTH(32), .SELECT_WIDTH(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (din),
    .shift_num(shift_num),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout),
    .guard    (grd),
    .round    (rnd),
    .sticky   (stk)
  );

  always #5 clk = ~clk;

  // Reference: place the operand atop a 64-bit word, shift, and read result and lost bits
  function automatic logic [34:0] model(input logic [31:0] d, input int s);
    logic [63:0] full;
    full = {d, 32'h0} >> s;
    return {full[63:32], full[31], full[30], |full[29:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand and advance just past the accepting edge
  task automatic accept(input logic [31:0] d, input logic [4:0] s);
    int n;
    in_valid  = 1'b1;
    din       = d;
    shift_num = s;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_timeout", 64'(n < 20), 64'd1);
    tick();
    in_valid  = 1'b0;
    din       = $urandom;
    shift_num = 5'($urandom);
  endtask

  // Full transaction; stall>0 holds out_ready low in DONE while offering a competing operand
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input int stall,
                        input logic [31:0] nd, input logic [4:0] ns);
    int cyc;
    logic [34:0] exp;
    exp = model(d, int'(s));
    out_ready = (stall == 0);
    accept(d, s);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      tick();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd5);
    chk("out", 64'(dout), 64'(exp[34:3]));
    chk("grs", 64'({grd, rnd, stk}), 64'(exp[2:0]));
    if (stall > 0) begin
      in_valid  = 1'b1;
      din       = nd;
      shift_num = ns;
      for (int i = 0; i < stall; i++) begin
        tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out", 64'({dout, grd, rnd, stk}), 64'(exp));
      end
      out_ready = 1'b1;
    end
    tick();
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [4:0]  rs;
    int          seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    shift_num = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'({dout, grd, rnd, stk}), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_exit_ready", 64'(in_ready), 64'd1);

    run_op(32'h8000_0001, 5'd0, 0, '0, '0);
    run_op(32'h0000_000F, 5'd2, 0, '0, '0);
    run_op(32'h0000_0005, 5'd4, 0, '0, '0);
    run_op(32'hFFFF_FFFF, 5'd31, 0, '0, '0);

    // Backpressure: a second operand waits until the first result is taken
    run_op(32'hDEAD_BEEF, 5'd7, 3, 32'h1234_5678, 5'd13);
    run_op(32'h1234_5678, 5'd13, 0, '0, '0);

    // Reset in the third shift cycle discards the operation
    accept(32'hCAFE_F00D, 5'd9);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", 64'({dout, grd, rnd, stk}), 64'd0);
    tick();
    chk("midrst_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("midrst_no_partial", 64'(seen), 64'd0);
    run_op(32'h0F0F_A5A5, 5'd17, 0, '0, '0);

    for (int i = 0; i < 24; i++) begin
      rd = $urandom;
      rs = 5'($urandom);
      run_op(rd, rs, int'($urandom_range(0, 2)), $urandom, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
